cart_rom_arb: RTL



---
 rtl/cart_rom_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/cart_rom_arb.sv
// cart_rom_arb: shares the cartridge ROM port between buffered HPS download writes and 2600 core fetches
module cart_rom_arb #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LEVEL = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic              dl_ovf,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W:0]   rom_size,
  output logic              core_hold,
  output logic              dl_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [ADDR_W+7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_nx;
  logic [SW-1:0] starve_cnt;
  logic [1:0] rd_pipe;
  logic [ADDR_W:0] wr_size;
  logic active_q, seen;
  logic in_range, full, empty, push, drop, force_wr, rd_go, pop, start, hold_nx, fall;
  always_comb begin
    in_range  = dl_addr[24:ADDR_W] == '0;
    full      = count == (PW+1)'(FIFO_DEPTH);
    empty     = count == '0;
    push      = dl_wr && in_range && !full;
    drop      = dl_wr && in_range && full;
    force_wr  = starve_cnt == SW'(STARVE_MAX);
    cpu_ready = !force_wr;
    rd_go     = cpu_rd && !force_wr;
    // a read can only lose to a forced write, so pop and rd_go are exclusive
    pop       = !empty && (force_wr || !cpu_rd);
    count_nx  = count + (PW+1)'(push) - (PW+1)'(pop);
    start     = dl_active && !active_q;
    wr_size   = {1'b0, dl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
    hold_nx   = dl_active || count_nx != '0 || pop;
    fall      = core_hold && !hold_nx;
  end
  always_ff @(posedge clk_sys)
    if (push) fifo[wr_ptr] <= {dl_addr[ADDR_W-1:0], dl_data};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rd_pipe    <= '0;
      active_q   <= 1'b0;
      seen       <= 1'b0;
      dl_wait    <= 1'b0;
      dl_ovf     <= 1'b0;
      cpu_data   <= '0;
      cpu_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      rom_size   <= '0;
      core_hold  <= 1'b1;
      dl_done    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      count      <= count_nx;
      starve_cnt <= (pop || empty) ? '0 : starve_cnt + SW'(rd_go);
      rd_pipe    <= {rd_pipe[0], rd_go};
      cpu_valid  <= rd_pipe[1];
      if (rd_pipe[1]) cpu_data <= mem_rdata;
      mem_we     <= pop;
      mem_addr   <= pop ? fifo[rd_ptr][ADDR_W+7:8] : rd_go ? cpu_addr : mem_addr;
      if (pop) mem_wdata <= fifo[rd_ptr][7:0];
      dl_wait    <= count_nx >= (PW+1)'(WAIT_LEVEL);
      active_q   <= dl_active;
      dl_ovf     <= drop || (dl_ovf && !start);
      rom_size   <= push && (start || wr_size > rom_size) ? wr_size : start ? '0 : rom_size;
      core_hold  <= hold_nx;
      dl_done    <= fall && seen;
      seen       <= dl_active || (seen && !fall);
    end
endmodule
